// File: rtl/mudi_unit.sv
// Multiply/divide unit for the EX stage.
// Owns HI/LO. A start computes the full 64-bit result at once and holds it
// pending. Busy then runs for the op's fixed latency before HI/LO commit.
module mudi_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  MuDiOp,
   input  logic        MuDiStart,
   input  logic        MuDiWrite,
   input  logic        flush,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] MuDiOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   logic          busy_q, busy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [63:0]   res_q, res_d;
   logic          res_vld_q, res_vld_d;

   logic          start_ok, wr_ok;
   logic          sgn_div, dvd_neg, dvs_neg;
   logic [31:0]   dvd, dvs, uq, ur, q_fix, r_fix;
   logic [63:0]   prod_s, prod_u;

   assign start_ok = MuDiStart & ~busy_q & ~flush & ~MuDiOp[2];
   // Start wins over a same-cycle write, so any asserted start masks the write.
   assign wr_ok    = MuDiWrite & ~MuDiStart & ~busy_q & ~flush;

   // Arithmetic: products and a single magnitude divider shared by div/divu.
   // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly.
   always_comb begin
      prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      prod_u  = {32'b0, A} * {32'b0, B};
      sgn_div = (MuDiOp == 3'd2);
      dvd_neg = sgn_div & A[31];
      dvs_neg = sgn_div & B[31];
      dvd     = dvd_neg ? -A : A;
      dvs     = dvs_neg ? -B : B;
      uq      = '0;
      ur      = '0;
      if (dvs != '0) begin
         uq = dvd / dvs;
         ur = dvd % dvs;
      end
      q_fix   = (dvd_neg ^ dvs_neg) ? -uq : uq;
      r_fix   = dvd_neg ? -ur : ur;
   end

   // Next-state: completion has precedence; otherwise accept start or mt write.
   always_comb begin
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      res_d     = res_q;
      res_vld_d = res_vld_q;
      if (busy_q) begin
         if (cnt_q == CW'(1)) begin
            busy_d    = 1'b0;
            cnt_d     = '0;
            res_vld_d = 1'b0;
            if (res_vld_q) begin
               hi_d = res_q[63:32];
               lo_d = res_q[31:0];
            end
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end else if (start_ok) begin
         busy_d    = 1'b1;
         cnt_d     = MuDiOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         // Divide by zero still runs the full latency but leaves HI/LO alone.
         res_vld_d = ~(MuDiOp[1] & (B == '0));
         case (MuDiOp[1:0])
            2'd0:    res_d = prod_s;
            2'd1:    res_d = prod_u;
            default: res_d = {r_fix, q_fix};
         endcase
      end else if (wr_ok) begin
         if (MuDiOp == 3'd4) hi_d = A;
         if (MuDiOp == 3'd5) lo_d = A;
      end
   end

   // State registers; reset aborts any in-flight op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
      end
   end

   assign Busy    = busy_q;
   assign HI      = hi_q;
   assign LO      = lo_q;
   assign MuDiOut = (MuDiOp == 3'd6) ? hi_q : lo_q;

endmodule

// File: tb/tb_mudi_unit.sv
// Bench for mudi_unit: directed cases plus random traffic against a
// timestamp-based reference model of HI/LO and Busy.
module tb_mudi_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  MuDiOp;
   logic        MuDiStart, MuDiWrite, flush;
   logic [31:0] A, B;
   logic        Busy;
   logic [31:0] MuDiOut, HI, LO;

   mudi_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .MuDiOp(MuDiOp), .MuDiStart(MuDiStart),
      .MuDiWrite(MuDiWrite), .flush(flush), .A(A), .B(B),
      .Busy(Busy), .MuDiOut(MuDiOut), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   // Reference model: architectural HI/LO, a pending result, and the edge
   // number at which the running op completes.
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_res;
   bit          m_vld;
   int          cyc, done;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_hi = '0; m_lo = '0; m_res = '0; m_vld = 0; done = cyc;
   endtask

   // Full 64-bit result of an op using plain integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         3'd0: return sa * sb;
         3'd1: return ua * ub;
         3'd2: begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: return {a % b, a / b};
      endcase
   endfunction

   // One cycle: drive at negedge, check current state, predict the edge.
   task automatic step(input logic [2:0] op, input logic st, input logic wr, input logic fl,
                       input logic [31:0] a, input logic [31:0] b);
      int e;
      MuDiOp = op; MuDiStart = st; MuDiWrite = wr; flush = fl; A = a; B = b;
      #1;
      chk("busy", {63'b0, Busy}, {63'b0, (cyc < done)});
      chk("hi", {32'b0, HI}, {32'b0, m_hi});
      chk("lo", {32'b0, LO}, {32'b0, m_lo});
      chk("mudiout", {32'b0, MuDiOut}, {32'b0, (op == 3'd6) ? m_hi : m_lo});
      e = cyc + 1;
      if (cyc < done) begin
         if (e == done && m_vld) begin
            m_hi = m_res[63:32];
            m_lo = m_res[31:0];
         end
      end else if (st && !fl && op < 3'd4) begin
         done  = e + ((op >= 3'd2) ? DC : MC);
         m_vld = !(op >= 3'd2 && b == 0);
         if (m_vld) m_res = ref_result(op, a, b);
      end else if (wr && !st && !fl) begin
         if (op == 3'd4) m_hi = a;
         if (op == 3'd5) m_lo = a;
      end
      cyc = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(3'd7, 0, 0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      reset = 1'b1; MuDiOp = '0; MuDiStart = 0; MuDiWrite = 0; flush = 0; A = '0; B = '0;
      cyc = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_busy", {63'b0, Busy}, 64'd0);
      chk("rst_hi", {32'b0, HI}, 64'd0);
      chk("rst_lo", {32'b0, LO}, 64'd0);
      reset = 1'b0;

      // mult -2 * 3
      step(3'd0, 1, 0, 0, 32'hFFFFFFFE, 32'd3);
      idle(MC);
      chk("mult_hi", {32'b0, HI}, 64'hFFFFFFFF);
      chk("mult_lo", {32'b0, LO}, 64'hFFFFFFFA);

      // multu max * max, Busy drops exactly MC cycles after start
      step(3'd1, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      idle(MC - 1);
      chk("multu_busy_last", {63'b0, Busy}, 64'd1);
      idle(1);
      chk("multu_busy_fall", {63'b0, Busy}, 64'd0);
      chk("multu_hi", {32'b0, HI}, 64'hFFFFFFFE);
      chk("multu_lo", {32'b0, LO}, 64'h00000001);

      // div -7 / 2
      step(3'd2, 1, 0, 0, 32'hFFFFFFF9, 32'd2);
      idle(DC);
      chk("div_lo", {32'b0, LO}, 64'hFFFFFFFD);
      chk("div_hi", {32'b0, HI}, 64'hFFFFFFFF);

      // div overflow case
      step(3'd2, 1, 0, 0, 32'h80000000, 32'hFFFFFFFF);
      idle(DC);
      chk("divovf_lo", {32'b0, LO}, 64'h80000000);
      chk("divovf_hi", {32'b0, HI}, 64'h0);

      // divide by zero leaves HI/LO alone
      step(3'd4, 0, 1, 0, 32'h11, 32'h0);
      step(3'd5, 0, 1, 0, 32'h22, 32'h0);
      step(3'd2, 1, 0, 0, 32'h5, 32'h0);
      idle(DC - 1);
      chk("divz_busy_last", {63'b0, Busy}, 64'd1);
      idle(1);
      chk("divz_busy_fall", {63'b0, Busy}, 64'd0);
      chk("divz_hi", {32'b0, HI}, 64'h11);
      chk("divz_lo", {32'b0, LO}, 64'h22);

      // flushed mthi is dropped
      step(3'd4, 0, 1, 0, 32'h1234, 32'h0);
      step(3'd5, 0, 1, 0, 32'h5678, 32'h0);
      step(3'd4, 0, 1, 1, 32'hAAAA, 32'h0);
      MuDiOp = 3'd6; #1;
      chk("flush_mfhi", {32'b0, MuDiOut}, 64'h1234);
      chk("flush_lo", {32'b0, LO}, 64'h5678);

      // start during Busy is ignored
      step(3'd0, 1, 0, 0, 32'd3, 32'd4);
      step(3'd1, 1, 0, 0, 32'd100, 32'd100);
      step(3'd2, 1, 0, 0, 32'd100, 32'd7);
      idle(MC - 2);
      MuDiOp = 3'd7; #1;
      chk("restart_mflo", {32'b0, MuDiOut}, 64'd12);
      chk("restart_hi", {32'b0, HI}, 64'd0);

      // reset in the middle of a divu
      step(3'd3, 1, 0, 0, 32'd100, 32'd7);
      idle(2);
      reset = 1'b1;
      #1;
      chk("midrst_busy", {63'b0, Busy}, 64'd0);
      chk("midrst_hi", {32'b0, HI}, 64'd0);
      chk("midrst_lo", {32'b0, LO}, 64'd0);
      model_reset();
      @(posedge clk);
      cyc++;
      done = cyc;
      @(negedge clk);
      reset = 1'b0;
      idle(DC + 2);
      chk("postrst_lo", {32'b0, LO}, 64'd0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 15);
         if ($urandom_range(0, 9) == 0) rb = 32'hFFFFFFFF;
         step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), ra, rb);
      end
      idle(DC + 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
